fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one synchronous FIFO's write port between NUM_REQ independent requesters. It sequences each write through the FIFO's registered wr_ack/overflow response. It retries writes the FIFO rejected, and it releases a requester only after the write is confirmed. It sits between producer blocks and the FIFO write interface (data_in, wr_en, wr_ack, overflow, full).

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int FIFO_WIDTH_DEF = 16;

  // Arbiter sequencing states; one write walks IDLE -> ISSUE -> WAIT_ACK -> DONE,
  // detouring through RETRY whenever the FIFO does not confirm the word.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    DONE     = 3'd3,
    RETRY    = 3'd4
  } arb_state_e;

  // Saturating increments: statistics stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request found when
// scanning ptr+1, ptr+2, ... modulo NUM_REQ, so index ptr has lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest valid one wins last.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one synchronous FIFO write port between
// NUM_REQ requesters. Each write is confirmed through the FIFO's registered
// wr_ack/overflow before the requester is released; rejected words are retried
// from a local copy without giving up the grant.
//
// Handshake: a requester raises req_valid[i] with req_data slice i and holds both
// until it sees a one-cycle req_ready[i] pulse; that pulse means the word is in
// the FIFO. Keeping req_valid high after the pulse presents a new word.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   wr_count,
  output logic [7:0]                    retry_count
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [FIFO_WIDTH-1:0]   data_q, data_d;
  logic                    wr_en_q, wr_en_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic [15:0]             wr_cnt_q, wr_cnt_d;
  logic [7:0]              retry_q, retry_d;

  logic                    pick_any;
  logic [IDW-1:0]          pick_idx;
  logic [FIFO_WIDTH-1:0]   req_word [NUM_REQ];

  // Unpack the flat data bus so the winner's word can be selected by index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state and next-output logic; every output is produced from a register.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    wr_en_d  = 1'b0;
    ready_d  = '0;
    wr_cnt_d = wr_cnt_q;
    retry_d  = retry_q;
    case (state_q)
      IDLE: begin
        // A full FIFO blocks new grants; the word would only be rejected.
        if (pick_any && !fifo_full) begin
          grant_d = pick_idx;
          data_d  = req_word[pick_idx];
          wr_en_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An overflow flag means the word was dropped even if ack were also set.
        if (fifo_wr_ack && !fifo_overflow) begin
          ready_d[grant_q] = 1'b1;
          rr_ptr_d         = grant_q;
          wr_cnt_d         = sat_inc16(wr_cnt_q);
          state_d          = DONE;
        end else begin
          retry_d = sat_inc8(retry_q);
          state_d = RETRY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      RETRY: begin
        // Grant, data and rr_ptr stay put so the requester keeps its slot.
        if (!fifo_full) begin
          wr_en_d = 1'b1;
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDW'(NUM_REQ - 1);
      grant_q  <= '0;
      data_q   <= '0;
      wr_en_q  <= 1'b0;
      ready_q  <= '0;
      busy_q   <= 1'b0;
      wr_cnt_q <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      wr_en_q  <= wr_en_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      wr_cnt_q <= wr_cnt_d;
      retry_q  <= retry_d;
    end
  end

  assign req_ready    = ready_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign wr_count     = wr_cnt_q;
  assign retry_count  = retry_q;

endmodule
